// File: rtl/aes_pkg.sv
// Shared AES-core types and constants used by the S-box ROM arbiter.
package aes_pkg;

  localparam int SBOX_ADDR_W = 8;
  localparam int SBOX_DATA_W = 8;

  localparam int REQ_SUBBYTES = 0;
  localparam int REQ_KEYEXP   = 1;

  typedef enum logic {ARB, LOCKED} sbox_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder: first asserted req at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_any
);

  localparam logic [IDX_W:0] NR = (IDX_W+1)'(NUM_REQ);

  always_comb begin
    logic [IDX_W:0]   j;
    logic [IDX_W-1:0] idx;
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = {1'b0, ptr} + (IDX_W+1)'(i);
      if (j >= NR) j = j - NR;
      idx = j[IDX_W-1:0];
      if (!win_any && req[idx]) begin
        win_any      = 1'b1;
        win_idx      = idx;
        win_oh[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sbox_rom_arbiter.sv
// Shares one registered-read S-box ROM between SubBytes and key expansion:
// round-robin grant with bounded burst lock, tag pipe routes data back.
module sbox_rom_arbiter
  import aes_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ROM_LAT  = 1,
  parameter int MAX_LOCK = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*SBOX_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]             lock,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [SBOX_DATA_W-1:0]         rsp_data,
  output logic [SBOX_ADDR_W-1:0]         rom_addr,
  input  logic [SBOX_DATA_W-1:0]         rom_data,
  output logic                           busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LOCK);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  sbox_arb_state_t                state_q, state_d;
  logic [IDX_W-1:0]               ptr_q, ptr_d;
  logic [IDX_W-1:0]               owner_q, owner_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [SBOX_ADDR_W-1:0]         rom_addr_q, rom_addr_d;
  logic [ROM_LAT:0]               vld_pipe_q, vld_pipe_d;
  logic [ROM_LAT:0][IDX_W-1:0]    own_pipe_q, own_pipe_d;

  logic [NUM_REQ-1:0][SBOX_ADDR_W-1:0] addr_arr;
  logic [NUM_REQ-1:0] arb_oh, owner_oh;
  logic [IDX_W-1:0]   arb_idx, gnt_idx;
  logic               arb_any, gnt_any, hold;

  assign addr_arr = req_addr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (arb_oh),
    .win_idx (arb_idx),
    .win_any (arb_any)
  );

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) owner_oh[i] = (owner_q == IDX_W'(i));
  end

  // When the burst ends, the same cycle falls through to ARB rules so the
  // next requester is served without a bubble (ptr already points past owner).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    hold    = (state_q == LOCKED) && req[owner_q] && lock[owner_q] && (cnt_q < CNT_MAX);
    if (hold) begin
      gnt_any = 1'b1;
      gnt_idx = owner_q;
      gnt     = owner_oh;
      cnt_d   = cnt_q + CNT_W'(1);
    end else begin
      state_d = ARB;
      cnt_d   = '0;
      if (arb_any) begin
        gnt_any = 1'b1;
        gnt_idx = arb_idx;
        gnt     = arb_oh;
        ptr_d   = (arb_idx == IDX_LAST) ? '0 : arb_idx + IDX_W'(1);
        if (lock[arb_idx]) begin
          state_d = LOCKED;
          owner_d = arb_idx;
          cnt_d   = CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rom_addr_d    = gnt_any ? addr_arr[gnt_idx] : rom_addr_q;
    vld_pipe_d    = vld_pipe_q;
    own_pipe_d    = own_pipe_q;
    vld_pipe_d[0] = gnt_any;
    own_pipe_d[0] = gnt_idx;
    for (int s = 1; s <= ROM_LAT; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      own_pipe_d[s] = own_pipe_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      vld_pipe_q <= '0;
      own_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      vld_pipe_q <= vld_pipe_d;
      own_pipe_q <= own_pipe_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid[i] = vld_pipe_q[ROM_LAT] && (own_pipe_q[ROM_LAT] == IDX_W'(i));
  end

  assign rsp_data = rom_data;
  assign rom_addr = rom_addr_q;
  assign busy     = |vld_pipe_q;

endmodule
